bcd_time_seq: RTL and testbench

BCD_TIME_SEQ -- requirements
Module: bcd_time_seq

---
 rtl/bcd_time_seq.sv | 118 +++++++++++
 tb/tb_bcd_time_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_seq.sv
// MM:SS BCD timekeeper that advances one digit per cycle through an external
// 4-bit ALU used as an incrementer (F = A + 1), carrying SU -> ST -> MU -> MT.
module bcd_time_seq #(
   parameter int SU_MAX = 9,
   parameter int ST_MAX = 5,
   parameter int MU_MAX = 9,
   parameter int MT_MAX = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       alu_f1,
   input  logic       alu_f2,
   input  logic       alu_f3,
   input  logic       alu_f4,
   input  logic       alu_cout,
   output logic       alu_a1,
   output logic       alu_a2,
   output logic       alu_a3,
   output logic       alu_a4,
   output logic       alu_b1,
   output logic       alu_b2,
   output logic       alu_b3,
   output logic       alu_b4,
   output logic       alu_s1,
   output logic       alu_s0,
   output logic       alu_cin,
   output logic [3:0] sec_u,
   output logic [3:0] sec_t,
   output logic [3:0] min_u,
   output logic [3:0] min_t,
   output logic       busy,
   output logic       rollover,
   output logic       overrun
);

   typedef enum logic [2:0] {IDLE, SU, ST, MU, MT} state_t;

   state_t     state, state_nxt;
   logic [3:0] alu_f;
   logic [3:0] digit;
   logic [3:0] limit;
   logic [3:0] digit_nxt;
   logic       at_limit;
   logic       pend;
   logic       unused_cout;

   // Digits never exceed 9, so the ALU carry-out carries no information here.
   assign unused_cout = alu_cout;
   assign alu_f       = {alu_f4, alu_f3, alu_f2, alu_f1};

   // Fixed add-one configuration of the ALU.
   assign {alu_b4, alu_b3, alu_b2, alu_b1} = 4'b0001;
   assign alu_s1  = 1'b0;
   assign alu_s0  = 1'b1;
   assign alu_cin = 1'b0;

   assign {alu_a4, alu_a3, alu_a2, alu_a1} = digit;
   assign busy = (state != IDLE);

   always_comb begin
      digit = 4'd0;
      limit = 4'hF;
      case (state)
         SU:      begin digit = sec_u; limit = 4'(SU_MAX); end
         ST:      begin digit = sec_t; limit = 4'(ST_MAX); end
         MU:      begin digit = min_u; limit = 4'(MU_MAX); end
         MT:      begin digit = min_t; limit = 4'(MT_MAX); end
         default: begin digit = 4'd0;  limit = 4'hF;       end
      endcase
   end

   assign at_limit  = (digit == limit);
   assign digit_nxt = at_limit ? 4'd0 : alu_f;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick || pend) state_nxt = SU;
         SU:      state_nxt = at_limit ? ST : IDLE;
         ST:      state_nxt = at_limit ? MU : IDLE;
         MU:      state_nxt = at_limit ? MT : IDLE;
         MT:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sec_u    <= 4'd0;
         sec_t    <= 4'd0;
         min_u    <= 4'd0;
         min_t    <= 4'd0;
         pend     <= 1'b0;
         overrun  <= 1'b0;
         rollover <= 1'b0;
      end else begin
         state    <= state_nxt;
         rollover <= (state == MT) && at_limit;
         case (state)
            SU:      sec_u <= digit_nxt;
            ST:      sec_t <= digit_nxt;
            MU:      min_u <= digit_nxt;
            MT:      min_t <= digit_nxt;
            default: ;
         endcase
         // IDLE always consumes the request (pending or live); only one can queue.
         if (state == IDLE) begin
            pend <= 1'b0;
         end else if (tick) begin
            if (!pend) pend    <= 1'b1;
            else       overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_time_seq.sv
// Directed bench for bcd_time_seq: behavioural ALU, seconds-count time model,
// and a queue of expected MM:SS readings checked whenever the block goes idle.
module tb_bcd_time_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       alu_f1, alu_f2, alu_f3, alu_f4, alu_cout;
   logic       alu_a1, alu_a2, alu_a3, alu_a4;
   logic       alu_b1, alu_b2, alu_b3, alu_b4;
   logic       alu_s1, alu_s0, alu_cin;
   logic [3:0] sec_u, sec_t, min_u, min_t;
   logic       busy, rollover, overrun;

   int compared   = 0;
   int mismatched = 0;
   int model_s    = 0;
   logic [15:0] exp_q[$];

   logic [3:0] a_bus, b_bus;
   logic [4:0] alu_sum;

   always #5 clk = ~clk;

   assign a_bus   = {alu_a4, alu_a3, alu_a2, alu_a1};
   assign b_bus   = {alu_b4, alu_b3, alu_b2, alu_b1};
   assign alu_sum = (!alu_s1 && alu_s0) ? ({1'b0, a_bus} + {1'b0, b_bus} + {4'd0, alu_cin}) : 5'd0;
   assign {alu_cout, alu_f4, alu_f3, alu_f2, alu_f1} = alu_sum;

   bcd_time_seq dut (
      .clk(clk), .rst(rst), .tick(tick),
      .alu_f1(alu_f1), .alu_f2(alu_f2), .alu_f3(alu_f3), .alu_f4(alu_f4),
      .alu_cout(alu_cout),
      .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_a3(alu_a3), .alu_a4(alu_a4),
      .alu_b1(alu_b1), .alu_b2(alu_b2), .alu_b3(alu_b3), .alu_b4(alu_b4),
      .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_cin(alu_cin),
      .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u), .min_t(min_t),
      .busy(busy), .rollover(rollover), .overrun(overrun)
   );

   function automatic logic [15:0] bcd(input int s);
      bcd = {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 16'd1, 16'd0);
      else check(tag, {min_t, min_u, sec_t, sec_u}, exp_q.pop_front());
   endtask

   // Starts and ends on a falling edge; the tick is sampled by the rising edge between.
   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int c = 0;
      while (busy && c < 8) begin
         @(negedge clk);
         c++;
      end
      ok = !busy;
      if (!ok) check("idle_timeout", 16'(busy), 16'd0);
   endtask

   task automatic advance_to(input int target);
      bit ok = 1'b1;
      while (model_s != target && ok) begin
         do_tick();
         model_s = (model_s + 1) % 3600;
         wait_idle(ok);
      end
      check("advance_time", {min_t, min_u, sec_t, sec_u}, bcd(model_s));
   endtask

   initial begin
      bit ok;
      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_time", {min_t, min_u, sec_t, sec_u}, 16'h0000);
      check("rst_flags", {13'd0, busy, rollover, overrun}, 16'd0);
      check("rst_alu", {7'd0, a_bus, b_bus, alu_s1, alu_s0, alu_cin}, {7'd0, 4'd0, 4'd1, 3'b010});
      rst = 1'b0;
      @(negedge clk);

      // Single tick from 00:00.
      do_tick();
      model_s = 1;
      exp_q.push_back(bcd(1));
      check("t1_busy", 16'(busy), 16'd1);
      check("t1_a_su", 16'(a_bus), 16'd0);
      @(negedge clk);
      check("t1_idle", {14'd0, busy, rollover}, 16'd0);
      sb_check("t1_time");

      // 00:09 -> 00:10 through SU then ST.
      advance_to(9);
      do_tick();
      model_s = 10;
      exp_q.push_back(bcd(10));
      check("c10_a_su", 16'(a_bus), 16'd9);
      @(negedge clk);
      check("c10_a_st", 16'(a_bus), 16'd0);
      check("c10_busy", 16'(busy), 16'd1);
      @(negedge clk);
      check("c10_idle", 16'(busy), 16'd0);
      sb_check("c10_time");

      // Async reset while in MU at 09:59 abandons the carry.
      advance_to(599);
      do_tick();
      @(negedge clk);
      @(negedge clk);
      check("rst_mu_a", 16'(a_bus), 16'd9);
      #1 rst = 1'b1;
      #1;
      check("rst_mu_time", {min_t, min_u, sec_t, sec_u}, 16'h0000);
      check("rst_mu_busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      model_s = 0;
      exp_q.delete();
      repeat (5) begin
         @(negedge clk);
         check("rst_mu_roll", {14'd0, rollover, busy}, 16'd0);
      end
      check("rst_mu_after", {min_t, min_u, sec_t, sec_u}, 16'h0000);

      // 09:59 with a second tick one cycle later: pend queues it.
      advance_to(599);
      do_tick();
      do_tick();
      exp_q.push_back(bcd(600));
      exp_q.push_back(bcd(601));
      model_s = 601;
      wait_idle(ok);
      sb_check("pend_10_00");
      @(negedge clk);
      check("pend_busy", 16'(busy), 16'd1);
      wait_idle(ok);
      sb_check("pend_10_01");
      check("pend_ovr", 16'(overrun), 16'd0);

      // Full 59:59 -> 00:00 wrap: four busy cycles, one rollover cycle.
      advance_to(3599);
      do_tick();
      model_s = 0;
      exp_q.push_back(bcd(0));
      check("wrap_a_su", {11'd0, busy, a_bus}, {11'd0, 1'b1, 4'd9});
      @(negedge clk);
      check("wrap_a_st", {11'd0, busy, a_bus}, {11'd0, 1'b1, 4'd5});
      @(negedge clk);
      check("wrap_a_mu", {11'd0, busy, a_bus}, {11'd0, 1'b1, 4'd9});
      @(negedge clk);
      check("wrap_a_mt", {10'd0, rollover, busy, a_bus}, {10'd0, 1'b0, 1'b1, 4'd5});
      @(negedge clk);
      check("wrap_roll_hi", {14'd0, rollover, busy}, 16'b10);
      sb_check("wrap_time");
      @(negedge clk);
      check("wrap_roll_lo", 16'(rollover), 16'd0);

      // Three back-to-back ticks at 59:59: third one dropped.
      advance_to(3599);
      tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      exp_q.push_back(bcd(0));
      exp_q.push_back(bcd(1));
      model_s = 1;
      check("ovr_set", 16'(overrun), 16'd1);
      wait_idle(ok);
      sb_check("ovr_00_00");
      @(negedge clk);
      wait_idle(ok);
      sb_check("ovr_00_01");
      repeat (3) @(negedge clk);
      check("ovr_sticky", {14'd0, overrun, busy}, 16'b10);
      check("sb_drained", 16'(exp_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
